ofm_addr_controller: RTL and testbench
======================================

# ofm_addr_controller

Write-side address generator for the systolic convolution datapath. It accepts the result words the array drains after each tile and produces OFM RAM write addresses and write enables. The OFM is stored channel-major: channel plane, then row, then column, which is the layout the next layer's IFM reader consumes. Tiles are visited in the same order the IFM reader uses (rows inside a column band, then the next band), and each column band is repeated per filter group of up to SYSTOLIC_SIZE filters.

## Interface

- SYSTOLIC_SIZE, 16: array width; maximum tile width and filters per group.
- OFM_RAM_SIZE, 705600: OFM RAM depth in words; AW = $clog2(OFM_RAM_SIZE).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on clk.
- start  in  1  one-cycle pulse that begins one tile; honoured only in IDLE.
- data_valid  in  1  the source presents one result word this cycle.
- ready  out  1  controller accepts data; a word transfers when data_valid && ready.
- ofm_addr  out  AW  write address, registered.
- write_en  out  1  RAM write strobe, registered.
- write_ofm_size  out  5  width of the current tile in pixels (1..SYSTOLIC_SIZE).
- tile_done  out  1  one-cycle pulse when a tile's last word has been issued.
- layer_done  out  1  one-cycle pulse, coincident with tile_done, on the last tile of the layer.
- ofm_size  in  9  OFM width and height (square), ≥1.
- ofm_channel  in  11  total filters in the layer, ≥1.

## Operation

- Configuration inputs must stay stable from the first start of a layer until layer_done.
- Tile position registers:
  - row: 0..ofm_size-1.
  - col_base: multiple of SYSTOLIC_SIZE.
  - filt_base: multiple of SYSTOLIC_SIZE.
  - All three reset to 0.
- States:
  - IDLE: ready=0, write_en=0. When start=1, go to SETUP.
  - SETUP (1 cycle):
    - write_ofm_size = min(SYSTOLIC_SIZE, ofm_size-col_base).
    - tile_filters = min(SYSTOLIC_SIZE, ofm_channel-filt_base).
    - plane = ofm_size*ofm_size.
    - line_addr = filt_base*plane + row*ofm_size + col_base.
    - addr = line_addr.
    - Clear pix and filt counters. Go to WRITE.
  - WRITE: ready=1. On each transfer:
    - Issue addr.
    - If pix < write_ofm_size-1: pix+1, addr+1.
    - Otherwise: pix=0, filt+1, line_addr += plane, addr = line_addr + plane.
    - The transfer with pix=write_ofm_size-1 and filt=tile_filters-1 is the last one; go to UPDATE.
  - UPDATE (1 cycle): ready=0; pulse tile_done; go to IDLE.
    - If row < ofm_size-1: row+1.
    - Else row=0, then:
      - If col_base+write_ofm_size < ofm_size: col_base += SYSTOLIC_SIZE.
      - Else col_base=0 and filt_base += SYSTOLIC_SIZE.
      - If the new filt_base ≥ ofm_channel: filt_base=0 and pulse layer_done.
- Incoming word order inside a tile is filter-major: all pixels of filter 0, then all pixels of filter 1, and so on.
- data_valid outside WRITE is ignored. start outside IDLE is ignored.
- Arithmetic:
  - Compute products at ≥24 bits, then truncate to AW.
  - No wrap check against OFM_RAM_SIZE; configuration guarantees fit.

## Timing

- Reset values: ofm_addr=0, write_en=0, ready=0, tile_done=0, layer_done=0, write_ofm_size=0, state IDLE, all counters and tile position 0.
- Latency:
  - start in cycle N → SETUP in N+1 → ready=1 from N+2.
  - A transfer in cycle M → write_en=1 with its ofm_addr in cycle M+1. The data path delays data by one register to match.
- write_en is low in any cycle that follows a cycle without a transfer. Gaps in data_valid only stall; they never skip or repeat an address.
- Last transfer in cycle M:
  - ready drops in M+1 (UPDATE).
  - tile_done (and layer_done if applicable) is high in M+1, together with the final write_en.
  - IDLE in M+2. The earliest next start is accepted in M+2.
- Minimum tile duration: 3 + write_ofm_size*tile_filters cycles.
- Reset asserted mid-tile: on the next edge the state returns to IDLE and all outputs and tile position take their reset values. A partially written tile is abandoned and not resumed.

## Test plan

- ofm_size=4, ofm_channel=2, continuous data_valid, first tile → write_ofm_size=4; addrs 0,1,2,3,16,17,18,19 on consecutive cycles; tile_done one cycle after the last transfer; no layer_done.
- Same config, 4 tiles → tile k writes 4k..4k+3 and 16+4k..19+4k; layer_done only with tile_done of tile 3; a fifth tile restarts at addr 0.
- ofm_size=20, ofm_channel=1 → tile 1 addrs 20..35 (width 16); tile 20 (col_base 16, row 0) width 4, addrs 16..19; layer_done on tile 39.
- ofm_size=4, ofm_channel=18 → tiles 0..3 cover 16 filters (64 words each); tile 4 has 2 filters, addrs 256..259 and 272..275; layer_done on tile 7.
- ofm_size=4, ofm_channel=2; data_valid toggling 1,0,0,1,… and a start pulse during WRITE → same address sequence as the first scenario, with write_en gaps matching the input gaps; the extra start has no effect.
- rst_n=1 after 3 transfers of a tile → the next cycle shows IDLE, ready=0, write_en=0, ofm_addr=0; a new start rewrites from addr 0.

Source files
------------

// File: rtl/ofm_addr_controller.sv
// OFM write-side address generator.
// Converts the filter-major stream of result words drained after each tile
// into channel-major OFM RAM write addresses and write strobes. It also keeps
// the tile position (row, column band, filter group) across tiles of a layer.
module ofm_addr_controller #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_RAM_SIZE  = 705600,
  localparam int AW = $clog2(OFM_RAM_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          data_valid,
  output logic          ready,
  output logic [AW-1:0] ofm_addr,
  output logic          write_en,
  output logic [4:0]    write_ofm_size,
  output logic          tile_done,
  output logic          layer_done,
  input  logic [8:0]    ofm_size,
  input  logic [10:0]   ofm_channel
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, UPDATE} state_t;

  state_t        state, state_nxt;
  logic [8:0]    row;
  logic [9:0]    col_base;     // one spare bit so col_base + width never wraps
  logic [11:0]   filt_base;    // one spare bit so filt_base + SYSTOLIC_SIZE never wraps
  logic [4:0]    tile_filters;
  logic [4:0]    pix, filt;
  logic [17:0]   plane;
  logic [AW-1:0] line_addr, addr;

  logic          xfer, last_xfer;
  logic [9:0]    col_rem;
  logic [11:0]   filt_rem;
  logic [31:0]   setup_plane, setup_line;
  logic          row_last, band_last, layer_end;
  logic [11:0]   filt_next;

  assign xfer      = (state == WRITE) && data_valid;
  assign last_xfer = xfer && (pix == write_ofm_size - 5'd1) && (filt == tile_filters - 5'd1);

  // Tile geometry evaluated from the current tile position (used in SETUP).
  assign col_rem     = {1'b0, ofm_size} - col_base;
  assign filt_rem    = {1'b0, ofm_channel} - filt_base;
  assign setup_plane = 32'(ofm_size) * 32'(ofm_size);
  assign setup_line  = 32'(filt_base) * setup_plane + 32'(row) * 32'(ofm_size) + 32'(col_base);

  // Position advance decisions (used in UPDATE).
  assign row_last  = (row == ofm_size - 9'd1);
  assign band_last = (col_base + 10'(write_ofm_size)) >= {1'b0, ofm_size};
  assign filt_next = filt_base + 12'(SYSTOLIC_SIZE);
  assign layer_end = row_last && band_last && (filt_next >= {1'b0, ofm_channel});

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = WRITE;
      WRITE:   if (last_xfer) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and tile-completion outputs decoded from the state.
  always_comb begin
    ready      = (state == WRITE);
    tile_done  = (state == UPDATE);
    layer_done = (state == UPDATE) && layer_end;
  end

  // Per-tile address walk: set up in SETUP, stepped on every transfer.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      write_ofm_size <= '0;
      tile_filters   <= '0;
      plane          <= '0;
      line_addr      <= '0;
      addr           <= '0;
      pix            <= '0;
      filt           <= '0;
    end else if (state == SETUP) begin
      write_ofm_size <= (col_rem > 10'(SYSTOLIC_SIZE)) ? 5'(SYSTOLIC_SIZE) : col_rem[4:0];
      tile_filters   <= (filt_rem > 12'(SYSTOLIC_SIZE)) ? 5'(SYSTOLIC_SIZE) : filt_rem[4:0];
      plane          <= setup_plane[17:0];
      line_addr      <= setup_line[AW-1:0];
      addr           <= setup_line[AW-1:0];
      pix            <= '0;
      filt           <= '0;
    end else if (xfer) begin
      if (pix < write_ofm_size - 5'd1) begin
        pix  <= pix + 5'd1;
        addr <= addr + AW'(1);
      end else begin
        // End of one filter's row segment: jump to the same line of the next plane.
        pix       <= '0;
        filt      <= filt + 5'd1;
        line_addr <= line_addr + AW'(plane);
        addr      <= line_addr + AW'(plane);
      end
    end
  end

  // Registered write port: the address issued is the one current at transfer time.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      write_en <= 1'b0;
      ofm_addr <= '0;
    end else begin
      write_en <= xfer;
      if (xfer) ofm_addr <= addr;
    end
  end

  // Tile position: rows inside a column band, then bands, then filter groups.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      row       <= '0;
      col_base  <= '0;
      filt_base <= '0;
    end else if (state == UPDATE) begin
      if (!row_last) begin
        row <= row + 9'd1;
      end else begin
        row <= '0;
        if (!band_last) begin
          col_base <= col_base + 10'(SYSTOLIC_SIZE);
        end else begin
          col_base  <= '0;
          filt_base <= (filt_next >= {1'b0, ofm_channel}) ? 12'd0 : filt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofm_addr_controller.sv
// Bench for ofm_addr_controller: a tile-index based address model feeds an
// expectation queue that a per-cycle compare process drains.
module tb_ofm_addr_controller;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n, start, data_valid;
  logic          ready, write_en, tile_done, layer_done;
  logic [AW-1:0] ofm_addr;
  logic [4:0]    write_ofm_size;
  logic [8:0]    ofm_size;
  logic [10:0]   ofm_channel;

  ofm_addr_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_valid(data_valid),
    .ready(ready), .ofm_addr(ofm_addr), .write_en(write_en),
    .write_ofm_size(write_ofm_size), .tile_done(tile_done), .layer_done(layer_done),
    .ofm_size(ofm_size), .ofm_channel(ofm_channel)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit last; bit layer; } exp_t;
  exp_t exp_q[$];
  int   ntests = 0, nfail = 0;
  int   tile_k = 0;
  bit   chk_on = 0;
  logic xfer_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tile k of a layer: filter groups outermost, then column bands, then rows.
  function automatic void tile_geom(input int sz, input int ch, input int k,
                                    output int g, output int band, output int r,
                                    output int w, output int tf, output bit lay);
    int bands, groups, total, kk, rem;
    bands  = (sz + 15) / 16;
    groups = (ch + 15) / 16;
    total  = sz * bands * groups;
    kk     = k % total;
    g      = kk / (sz * bands);
    rem    = kk % (sz * bands);
    band   = rem / sz;
    r      = rem % sz;
    w      = (sz - band * 16 > 16) ? 16 : sz - band * 16;
    tf     = (ch - g * 16 > 16) ? 16 : ch - g * 16;
    lay    = (kk == total - 1);
  endfunction

  // Address of the idx-th word (filter-major) of tile k.
  function automatic int model_addr(input int sz, input int ch, input int k, input int idx);
    int g, b, r, w, tf; bit lay;
    tile_geom(sz, ch, k, g, b, r, w, tf, lay);
    return (g * 16 + idx / w) * sz * sz + r * sz + b * 16 + idx % w;
  endfunction

  function automatic int model_w(input int sz, input int ch, input int k);
    int g, b, r, w, tf; bit lay;
    tile_geom(sz, ch, k, g, b, r, w, tf, lay);
    return w;
  endfunction

  function automatic int model_layer(input int sz, input int ch, input int k);
    int g, b, r, w, tf; bit lay;
    tile_geom(sz, ch, k, g, b, r, w, tf, lay);
    return int'(lay);
  endfunction

  task automatic push_tile(output int w, output int total);
    int g, b, r, tf; bit lay; exp_t e;
    tile_geom(int'(ofm_size), int'(ofm_channel), tile_k, g, b, r, w, tf, lay);
    total = w * tf;
    for (int i = 0; i < total; i++) begin
      e.addr  = model_addr(int'(ofm_size), int'(ofm_channel), tile_k, i);
      e.last  = (i == total - 1);
      e.layer = lay && (i == total - 1);
      exp_q.push_back(e);
    end
  endtask

  // Transfers seen at the edge decide whether write_en must follow.
  always @(posedge clk) xfer_prev <= data_valid && ready && !rst_n;

  // Per-cycle output check against the expectation queue.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("write_en_follows_xfer", int'(write_en), int'(xfer_prev));
      if (write_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(ofm_addr), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ofm_addr", int'(ofm_addr), e.addr);
          chk("tile_done", int'(tile_done), int'(e.last));
          chk("layer_done", int'(layer_done), int'(e.layer));
        end
      end else begin
        chk("tile_done_idle", int'(tile_done), 0);
        chk("layer_done_idle", int'(layer_done), 0);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b1; start = 1'b0; data_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    tile_k = 0;
  endtask

  // mode 0: continuous data_valid; mode 1: data_valid pattern 1,0,0,1,0,0...
  task automatic run_tile(input int mode, input bit extra_start);
    int w, total, sent, cyc;
    push_tile(w, total);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("setup_ready", int'(ready), 0);
    @(posedge clk); #1;
    chk("write_ready", int'(ready), 1);
    chk("write_ofm_size", int'(write_ofm_size), w);
    sent = 0; cyc = 0;
    while (sent < total && cyc < 400) begin
      data_valid = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      start      = extra_start && (cyc == 2);
      if (data_valid && ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    data_valid = 1'b0; start = 1'b0;
    chk("tile_words", sent, total);
    chk("update_ready", int'(ready), 0);
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    tile_k++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; data_valid = 1'b0;
    ofm_size = 9'd4; ofm_channel = 11'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_ofm_addr", int'(ofm_addr), 0);
    chk("rst_wsize", int'(write_ofm_size), 0);
    chk("rst_tile_done", int'(tile_done), 0);
    chk("rst_layer_done", int'(layer_done), 0);
    rst_n = 1'b0;
    chk_on = 1'b1;

    // Hand-computed pins of the model itself.
    chk("pin_4x2_t0_w0", model_addr(4, 2, 0, 0), 0);
    chk("pin_4x2_t0_w4", model_addr(4, 2, 0, 4), 16);
    chk("pin_4x2_t3_w7", model_addr(4, 2, 3, 7), 31);
    chk("pin_4x2_t4_w0", model_addr(4, 2, 4, 0), 0);
    chk("pin_20x1_t1_w0", model_addr(20, 1, 1, 0), 20);
    chk("pin_20x1_t1_w15", model_addr(20, 1, 1, 15), 35);
    chk("pin_20x1_t20_w0", model_addr(20, 1, 20, 0), 16);
    chk("pin_20x1_t20_w3", model_addr(20, 1, 20, 3), 19);
    chk("pin_20x1_t20_width", model_w(20, 1, 20), 4);
    chk("pin_20x1_t39_layer", model_layer(20, 1, 39), 1);
    chk("pin_20x1_t38_layer", model_layer(20, 1, 38), 0);
    chk("pin_4x18_t4_w0", model_addr(4, 18, 4, 0), 256);
    chk("pin_4x18_t4_w3", model_addr(4, 18, 4, 3), 259);
    chk("pin_4x18_t4_w4", model_addr(4, 18, 4, 4), 272);
    chk("pin_4x18_t4_w7", model_addr(4, 18, 4, 7), 275);

    // 4x4 OFM, 2 filters: a full layer plus one wrap-around tile.
    for (int i = 0; i < 5; i++) run_tile(0, 1'b0);

    // 20x20 OFM, 1 filter: two column bands, the second 4 pixels wide.
    ofm_size = 9'd20; ofm_channel = 11'd1;
    do_reset();
    for (int i = 0; i < 40; i++) run_tile(0, 1'b0);

    // 4x4 OFM, 18 filters: a full group of 16 then a group of 2.
    ofm_size = 9'd4; ofm_channel = 11'd18;
    do_reset();
    for (int i = 0; i < 8; i++) run_tile(0, 1'b0);

    // Stalling source and a stray start during WRITE.
    ofm_size = 9'd4; ofm_channel = 11'd2;
    do_reset();
    run_tile(1, 1'b1);
    run_tile(0, 1'b0);

    // Reset in the middle of a tile, then the first tile again from address 0.
    do_reset();
    begin
      int w, total;
      push_tile(w, total);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    data_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_write_en", int'(write_en), 0);
    chk("midrst_ofm_addr", int'(ofm_addr), 0);
    chk("midrst_wsize", int'(write_ofm_size), 0);
    exp_q.delete();
    tile_k = 0;
    run_tile(0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
